// File: rtl/inst_fetch_responder.sv
// Instruction-memory fetch responder: fixed-latency read pipeline feeding an in-order
// response queue, with credit-gated request acceptance, flush, and a program-load port.
module inst_fetch_responder #(
    parameter int unsigned AW     = 11,
    parameter int unsigned DW     = 9,
    parameter int unsigned DEPTH  = 2048,
    parameter int unsigned LAT    = 2,
    parameter int unsigned QDEPTH = 4
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          ReqValid,
    output logic          ReqReady,
    input  logic [AW-1:0] ReqAddr,
    input  logic          Flush,
    output logic          RspValid,
    input  logic          RspReady,
    output logic [DW-1:0] RspInstr,
    output logic [AW-1:0] RspAddr,
    output logic          RspErr,
    input  logic          LoadEn,
    output logic          LoadReady,
    input  logic [AW-1:0] LoadAddr,
    input  logic [DW-1:0] LoadData,
    output logic          Busy
);

    localparam int unsigned IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned QAW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int unsigned CW  = $clog2(QDEPTH + 1);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_LOAD = 1'b1
    } state_e;

    state_e          state_q, state_d;

    logic [LAT-1:0]  pvld_q, pvld_d;
    logic [AW-1:0]   paddr_q [LAT];
    logic [LAT-1:0]  perr_q;

    logic [DW-1:0]   qinstr_q [QDEPTH];
    logic [AW-1:0]   qaddr_q  [QDEPTH];
    logic [QDEPTH-1:0] qerr_q;
    logic [QAW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [QAW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   outst_q, outst_d;

    logic            rsp_valid_q;
    logic            busy_q;
    logic            load_ready_q;

    logic [DW-1:0]   mem_q [DEPTH];

    logic            accept;
    logic            push;
    logic            pop;
    logic            load_wr;
    logic            req_in_range;
    logic            load_in_range;
    logic [DW-1:0]   rd_instr;

    function automatic logic [QAW-1:0] ptr_inc(input logic [QAW-1:0] p);
        return (32'(p) == QDEPTH - 1) ? '0 : p + QAW'(1);
    endfunction

    // Request/response handshakes; a flush edge suppresses both accept and pop.
    assign ReqReady      = (state_q == ST_RUN) && !LoadEn && !Flush && (outst_q < CW'(QDEPTH));
    assign accept        = ReqValid && ReqReady;
    assign pop           = rsp_valid_q && RspReady && !Flush;
    assign push          = pvld_q[LAT-1] && !Flush;
    assign req_in_range  = 32'(ReqAddr) < DEPTH;
    assign load_in_range = 32'(LoadAddr) < DEPTH;
    assign load_wr       = LoadEn && load_ready_q;

    assign rd_instr = perr_q[LAT-1] ? '0 : mem_q[IW'(paddr_q[LAT-1])];

    always_comb begin
        state_d  = state_q;
        pvld_d   = '0;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        outst_d  = outst_q;

        case (state_q)
            ST_RUN:  if (LoadEn && (outst_q == '0)) state_d = ST_LOAD;
            ST_LOAD: if (!LoadEn) state_d = ST_RUN;
            default: state_d = ST_RUN;
        endcase

        if (Flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
            outst_d  = '0;
        end else begin
            pvld_d[0] = accept;
            for (int i = 1; i < LAT; i++) pvld_d[i] = pvld_q[i-1];
            if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            cnt_d   = cnt_q + CW'(push) - CW'(pop);
            outst_d = outst_q + CW'(accept) - CW'(pop);
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q      <= ST_RUN;
            pvld_q       <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
            outst_q      <= '0;
            rsp_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            load_ready_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            pvld_q       <= pvld_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
            outst_q      <= outst_d;
            rsp_valid_q  <= (cnt_d != '0);
            busy_q       <= (outst_d != '0);
            load_ready_q <= (state_d == ST_LOAD) || (outst_d == '0);
        end
    end

    // Pipeline payload shifts unconditionally; only the valid bits carry meaning.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < LAT; i++) paddr_q[i] <= '0;
            perr_q <= '0;
        end else begin
            paddr_q[0] <= ReqAddr;
            perr_q[0]  <= !req_in_range;
            for (int i = 1; i < LAT; i++) begin
                paddr_q[i] <= paddr_q[i-1];
                perr_q[i]  <= perr_q[i-1];
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < QDEPTH; i++) begin
                qinstr_q[i] <= '0;
                qaddr_q[i]  <= '0;
            end
            qerr_q <= '0;
        end else if (push) begin
            qinstr_q[wr_ptr_q] <= rd_instr;
            qaddr_q[wr_ptr_q]  <= paddr_q[LAT-1];
            qerr_q[wr_ptr_q]   <= perr_q[LAT-1];
        end
    end

    // Instruction store is intentionally not reset so a program survives a core reset.
    always_ff @(posedge Clk) begin
        if (load_wr && load_in_range) mem_q[IW'(LoadAddr)] <= LoadData;
    end

    assign RspValid  = rsp_valid_q;
    assign RspInstr  = qinstr_q[rd_ptr_q];
    assign RspAddr   = qaddr_q[rd_ptr_q];
    assign RspErr    = qerr_q[rd_ptr_q];
    assign Busy      = busy_q;
    assign LoadReady = load_ready_q;

endmodule
